alu_cmd_engine: RTL and testbench

Sequential command/response front end for the team's 4-bit arithmetic/logic datapath. It accepts one operation (opcode plus operands A and B) over a valid/ready command channel and computes it. Add, subtract and logic operations take one cycle. Multiply (shift-add) and divide (restoring) each take W iterations. The result is returned on a valid/ready response channel. It is the initiator-side counterpart of the combinational operation block: it drives operands, sequences multi-cycle operations and hands results to a consumer.

---
 rtl/alu_cmd_engine.sv | 214 +++++++++++++++++++++
 tb/tb_alu_cmd_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_engine.sv
// Command/response front end for the 4-bit ALU datapath: single-cycle
// arithmetic/logic ops, shift-add multiply and restoring divide.
module alu_cmd_engine #(
   parameter int unsigned W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [W-1:0]      cmd_a,
   input  logic [W-1:0]      cmd_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [2*W-1:0]    rsp_data,
   output logic [W-1:0]      rsp_rem,
   output logic              rsp_err,
   output logic              busy
);

   localparam int unsigned RW = 2 * W;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_NOTA = 4'd7;
   localparam logic [3:0] OP_NOTB = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_RESP} state_t;

   state_t         state, state_n;
   logic           accept;
   logic           last_iter;

   logic [RW-1:0]  acc, acc_n;
   logic [RW-1:0]  mcand, mcand_n;
   logic [W-1:0]   mul_b, mul_b_n;
   logic [W-1:0]   div_a, div_a_n;
   logic [W-1:0]   div_b, div_b_n;
   logic [W-1:0]   rem, rem_n;
   logic [W-1:0]   quo, quo_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [W:0]     trial;
   logic           q_bit;

   logic [RW-1:0]  rsp_data_n;
   logic [W-1:0]   rsp_rem_n;
   logic           rsp_err_n;

   logic [RW-1:0]  one_data;
   logic [W-1:0]   one_rem;
   logic           one_err;
   logic [W-1:0]   and_ab, or_ab, xor_ab, not_a, not_b;

   assign accept    = cmd_valid && cmd_ready;
   assign last_iter = (cnt == CW'(W - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (cmd_op == OP_MUL)                          state_n = S_MUL;
               else if (cmd_op == OP_DIV && cmd_b != '0)      state_n = S_DIV;
               else                                           state_n = S_RESP;
            end
         end
         S_MUL, S_DIV: if (last_iter) state_n = S_RESP;
         S_RESP:       if (rsp_ready) state_n = S_IDLE;
         default:      state_n = S_IDLE;
      endcase
   end

   // Single-cycle results straight from the command operands
   always_comb begin
      and_ab   = cmd_a & cmd_b;
      or_ab    = cmd_a | cmd_b;
      xor_ab   = cmd_a ^ cmd_b;
      not_a    = ~cmd_a;
      not_b    = ~cmd_b;
      one_data = '0;
      one_rem  = '0;
      one_err  = 1'b0;
      case (cmd_op)
         OP_ADD:  one_data = RW'(cmd_a) + RW'(cmd_b);
         OP_SUB:  one_data = RW'(cmd_a) - RW'(cmd_b);
         OP_MUL:  one_data = '0;
         OP_DIV: begin
            one_data = RW'({W{1'b1}});
            one_rem  = cmd_a;
            one_err  = 1'b1;
         end
         OP_AND:  one_data = RW'(and_ab);
         OP_OR:   one_data = RW'(or_ab);
         OP_XOR:  one_data = RW'(xor_ab);
         OP_NOTA: one_data = RW'(not_a);
         OP_NOTB: one_data = RW'(not_b);
         default: one_err  = 1'b1;
      endcase
   end

   // Output / datapath next values; rsp_* only change when entering RESP
   always_comb begin
      acc_n      = acc;
      mcand_n    = mcand;
      mul_b_n    = mul_b;
      div_a_n    = div_a;
      div_b_n    = div_b;
      rem_n      = rem;
      quo_n      = quo;
      cnt_n      = cnt;
      rsp_data_n = rsp_data;
      rsp_rem_n  = rsp_rem;
      rsp_err_n  = rsp_err;
      trial      = {rem, div_a[W-1]};
      q_bit      = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               acc_n   = '0;
               mcand_n = RW'(cmd_a);
               mul_b_n = cmd_b;
               div_a_n = cmd_a;
               div_b_n = cmd_b;
               rem_n   = '0;
               quo_n   = '0;
               cnt_n   = '0;
               if (state_n == S_RESP) begin
                  rsp_data_n = one_data;
                  rsp_rem_n  = one_rem;
                  rsp_err_n  = one_err;
               end
            end
         end
         S_MUL: begin
            acc_n   = acc + (mul_b[0] ? mcand : '0);
            mcand_n = mcand << 1;
            mul_b_n = mul_b >> 1;
            cnt_n   = cnt + CW'(1);
            if (last_iter) begin
               rsp_data_n = acc_n;
               rsp_rem_n  = '0;
               rsp_err_n  = 1'b0;
            end
         end
         S_DIV: begin
            // Restoring step: bring down the next dividend bit, subtract if it fits
            if (trial >= {1'b0, div_b}) begin
               rem_n = W'(trial - {1'b0, div_b});
               q_bit = 1'b1;
            end else begin
               rem_n = W'(trial);
            end
            quo_n   = {quo[W-2:0], q_bit};
            div_a_n = div_a << 1;
            cnt_n   = cnt + CW'(1);
            if (last_iter) begin
               rsp_data_n = RW'(quo_n);
               rsp_rem_n  = rem_n;
               rsp_err_n  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
         rsp_data  <= '0;
         rsp_rem   <= '0;
         rsp_err   <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mul_b     <= '0;
         div_a     <= '0;
         div_b     <= '0;
         rem       <= '0;
         quo       <= '0;
         cnt       <= '0;
      end else begin
         cmd_ready <= (state_n == S_IDLE);
         rsp_valid <= (state_n == S_RESP);
         busy      <= (state_n != S_IDLE);
         rsp_data  <= rsp_data_n;
         rsp_rem   <= rsp_rem_n;
         rsp_err   <= rsp_err_n;
         acc       <= acc_n;
         mcand     <= mcand_n;
         mul_b     <= mul_b_n;
         div_a     <= div_a_n;
         div_b     <= div_b_n;
         rem       <= rem_n;
         quo       <= quo_n;
         cnt       <= cnt_n;
      end
   end

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Directed self-checking bench for alu_cmd_engine (W=4); outputs sampled on
// the falling edge, expected values hand-computed.
module tb_alu_cmd_engine;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [3:0] rsp_rem;
   logic       rsp_err;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   alu_cmd_engine #(.W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_rem   (rsp_rem),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one command at a falling edge; returns just after the accepting edge
   task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Wait (bounded) for the response, check latency and payload, then the handshake
   task automatic expect_rsp(input string tag, input int lat_exp,
                             input logic [7:0] data, input logic [3:0] rem, input logic err);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         check({tag, "_busy"}, 32'(busy), 32'd1);
      end while (!rsp_valid && lat < 20);
      if (!rsp_valid) begin
         check({tag, "_timeout"}, 32'(rsp_valid), 32'd1);
         return;
      end
      check({tag, "_lat"},  32'(lat),      32'(lat_exp));
      check({tag, "_data"}, 32'(rsp_data), 32'(data));
      check({tag, "_rem"},  32'(rsp_rem),  32'(rem));
      check({tag, "_err"},  32'(rsp_err),  32'(err));
      if (rsp_ready) begin
         @(negedge clk);
         check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
         check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 4'd0;
      cmd_a     = 4'd1;
      cmd_b     = 4'd2;
      rsp_ready = 1'b1;

      // Reset held 3 cycles with a command pending
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_outputs",   32'({rsp_data, rsp_rem, rsp_err, busy}), 32'd0);
      end
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rel_busy",      32'(busy),      32'd0);

      // Single-cycle arithmetic, A=10 B=15
      issue(4'd0, 4'b1010, 4'b1111);
      expect_rsp("add", 1, 8'h19, 4'h0, 1'b0);
      issue(4'd1, 4'b1010, 4'b1111);
      expect_rsp("sub", 1, 8'hFB, 4'h0, 1'b0);

      // Multiply: 5-cycle latency, busy throughout
      issue(4'd2, 4'd10, 4'd15);
      expect_rsp("mul", 5, 8'h96, 4'h0, 1'b0);
      issue(4'd4, 4'd10, 4'd15);
      expect_rsp("and", 1, 8'h0A, 4'h0, 1'b0);
      issue(4'd5, 4'd10, 4'd5);
      expect_rsp("or", 1, 8'h0F, 4'h0, 1'b0);
      issue(4'd6, 4'd12, 4'd10);
      expect_rsp("xor", 1, 8'h06, 4'h0, 1'b0);
      issue(4'd8, 4'd0, 4'd3);
      expect_rsp("notb", 1, 8'h0C, 4'h0, 1'b0);
      issue(4'd2, 4'd15, 4'd15);
      expect_rsp("mul_max", 5, 8'hE1, 4'h0, 1'b0);

      // Divide
      issue(4'd3, 4'd15, 4'd4);
      expect_rsp("div_15_4", 5, 8'h03, 4'h3, 1'b0);
      issue(4'd3, 4'd10, 4'd15);
      expect_rsp("div_10_15", 5, 8'h00, 4'hA, 1'b0);
      issue(4'd3, 4'd10, 4'd0);
      expect_rsp("div_by0", 1, 8'h0F, 4'hA, 1'b1);
      issue(4'd3, 4'd13, 4'd1);
      expect_rsp("div_13_1", 5, 8'h0D, 4'h0, 1'b0);

      // Backpressure on NOTA; a command offered meanwhile must be ignored
      rsp_ready = 1'b0;
      issue(4'd7, 4'd10, 4'd0);
      expect_rsp("nota", 1, 8'h05, 4'h0, 1'b0);
      cmd_valid = 1'b1;
      cmd_op    = 4'd0;
      cmd_a     = 4'd1;
      cmd_b     = 4'd1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_valid",     32'(rsp_valid), 32'd1);
         check("bp_data",      32'(rsp_data),  32'h05);
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(rsp_valid), 32'd0);
      check("bp_release_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      check("bp_no_phantom", 32'(rsp_valid), 32'd0);
      check("bp_idle_busy",  32'(busy),      32'd0);

      // Illegal opcode
      issue(4'd12, 4'd7, 4'd3);
      expect_rsp("illegal", 1, 8'h00, 4'h0, 1'b1);

      // Reset two cycles into a multiply aborts it
      issue(4'd2, 4'd3, 4'd3);
      @(negedge clk);
      check("abort_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_valid", 32'(rsp_valid), 32'd0);
      check("abort_busy",  32'(busy),      32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      issue(4'd0, 4'd3, 4'd4);
      expect_rsp("add_after_abort", 1, 8'h07, 4'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
